// File: rtl/trace_loader_pkg.sv
// rtl/trace_loader_pkg.sv - shared register map, bit indices and FSM states for the trace SRAM loader
// Purpose: register offsets (wbs_adr_i[3:2]), CTRL/STATUS bit positions and the loader/player state enum.
// Ports: none (package).
package trace_loader_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_LOOP  = 2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVF   = 3;

    // Top uses IDLE/WR/WR_ACK, the player uses IDLE and the PB_* states.
    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_ACK,
        PB_RD,
        PB_WAIT,
        PB_EMIT,
        PB_GAP
    } loader_state_t;

endpackage

// File: rtl/trace_player.sv
// rtl/trace_player.sv - playback sequencer reading trace words from SRAM and strobing them out
// Purpose: on start walks rd_ptr 0..count-1; per word: SRAM read, wait, emit strobe, GAP idle cycles.
// Ports: clk, rst_n (async active-low); start/abort/loop/count control in; sram_dout read data in;
//        rd_en/rd_addr SRAM read request out; trace_ready/trace_addr trace output;
//        busy (sequencer active); pass_done (asserted in the cycle the final word of a pass ends).
module trace_player
    import trace_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int GAP    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              loop,
    input  logic [ADDR_W:0]   count,
    input  logic [31:0]       sram_dout,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              trace_ready,
    output logic [31:0]       trace_addr,
    output logic              busy,
    output logic              pass_done
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    loader_state_t     st;
    logic [ADDR_W-1:0] rd_ptr;
    logic [GW-1:0]     gap_cnt;
    logic              word_end;
    logic              last_word;

    // With GAP=0 the emit cycle is also the last cycle of the word.
    assign word_end  = (GAP == 0) ? (st == PB_EMIT) : ((st == PB_GAP) && (gap_cnt == '0));
    assign last_word = ({1'b0, rd_ptr} == (count - 1'b1));
    assign pass_done = word_end & last_word & ~abort;
    assign busy      = (st != IDLE);
    assign rd_addr   = rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            rd_ptr      <= '0;
            gap_cnt     <= '0;
            rd_en       <= 1'b0;
            trace_ready <= 1'b0;
            trace_addr  <= '0;
        end else begin
            trace_ready <= 1'b0;
            rd_en       <= 1'b0;
            if (abort) begin
                st <= IDLE;
            end else begin
                case (st)
                    IDLE: begin
                        if (start) begin
                            rd_ptr <= '0;
                            rd_en  <= 1'b1;
                            st     <= PB_RD;
                        end
                    end
                    PB_RD:   st <= PB_WAIT;
                    PB_WAIT: begin
                        trace_addr  <= sram_dout;
                        trace_ready <= 1'b1;
                        st          <= PB_EMIT;
                    end
                    PB_EMIT: begin
                        if (GAP != 0) begin
                            gap_cnt <= GW'(GAP - 1);
                            st      <= PB_GAP;
                        end
                    end
                    PB_GAP: begin
                        if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                    end
                    default: st <= IDLE;
                endcase
                // End-of-word decision overrides the per-state defaults above.
                if (word_end) begin
                    if (!last_word) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        rd_en  <= 1'b1;
                        st     <= PB_RD;
                    end else if (loop) begin
                        rd_ptr <= '0;
                        rd_en  <= 1'b1;
                        st     <= PB_RD;
                    end else begin
                        st <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/trace_sram_loader.sv
// rtl/trace_sram_loader.sv - Wishbone-loaded trace SRAM with in-order playback to the cache model
// Purpose: Wishbone register window (CTRL/STATUS/DATA/COUNT) at BASE_ADDR, SRAM write path,
//          SRAM port mux, playback via trace_player. Optional macro TRACE_LOOP_EN adds CTRL bit2 LOOP.
// Ports: clk, reset_n (async active-low); wbs_* Wishbone responder; sram_* port 0 of sram_32_256;
//        trace_ready_o/trace_addr_o trace strobe and word; irq_o playback-done interrupt.
module trace_sram_loader
    import trace_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          ADDR_W    = 8,
    parameter int          GAP       = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [31:0]       sram_din0,
    input  logic [31:0]       sram_dout0,
    output logic              trace_ready_o,
    output logic [31:0]       trace_addr_o,
    output logic              irq_o
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     st;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count;
    logic              done, overflow, full, busy, loop_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_din;
    logic              pb_rd_en, pass_done;
    logic [ADDR_W-1:0] pb_rd_addr;
    logic              hit, accept, reg_wr, data_push;
    logic              ctrl_start, ctrl_clear, pb_start;
    logic [1:0]        sel;
    logic [31:0]       rdata;
    logic              unused_bits;

    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0]};

    // A new request is taken only in IDLE and not while the previous ack is still out,
    // so a master holding stb through its ack cycle is never served twice.
    assign hit        = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign accept     = hit & ~wbs_ack_o & (st == IDLE);
    assign sel        = wbs_adr_i[3:2];
    assign reg_wr     = accept & wbs_we_i;
    assign ctrl_start = reg_wr & (sel == REG_CTRL) & wbs_dat_i[CTRL_START];
    assign ctrl_clear = reg_wr & (sel == REG_CTRL) & wbs_dat_i[CTRL_CLEAR];
    assign pb_start   = ctrl_start & ~ctrl_clear & ~busy & (count != '0);
    assign full       = (count == DEPTH);
    assign data_push  = reg_wr & (sel == REG_DATA) & ~busy & ~full;
    assign irq_o      = done & ~busy;

`ifdef TRACE_LOOP_EN
    logic loop_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        loop_q <= 1'b0;
        else if (reg_wr && sel == REG_CTRL) loop_q <= wbs_dat_i[CTRL_LOOP];
    end
    assign loop_en = loop_q;
`else
    assign loop_en = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL:   rdata[CTRL_LOOP] = loop_en;
            REG_STATUS: begin
                rdata[STAT_BUSY] = busy;
                rdata[STAT_DONE] = done;
                rdata[STAT_FULL] = full;
                rdata[STAT_OVF]  = overflow;
            end
            REG_COUNT:  rdata[ADDR_W:0] = count;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_din    <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            wr_en     <= 1'b0;
            case (st)
                IDLE: begin
                    if (accept) begin
                        if (data_push) begin
                            st      <= WR;
                            wr_en   <= 1'b1;
                            wr_addr <= wr_ptr;
                            wr_din  <= wbs_dat_i;
                        end else begin
                            wbs_ack_o <= 1'b1;
                            if (!wbs_we_i) wbs_dat_o <= rdata;
                            if (wbs_we_i && sel == REG_STATUS) begin
                                if (wbs_dat_i[STAT_DONE]) done     <= 1'b0;
                                if (wbs_dat_i[STAT_OVF])  overflow <= 1'b0;
                            end
                            // A DATA write that reaches here was refused (full or busy).
                            if (wbs_we_i && sel == REG_DATA) overflow <= 1'b1;
                            if (ctrl_start && !busy && count == '0) done <= 1'b1;
                        end
                    end
                end
                WR: begin
                    st        <= WR_ACK;
                    wbs_ack_o <= 1'b1;
                    wr_ptr    <= wr_ptr + 1'b1;
                    count     <= count + 1'b1;
                end
                WR_ACK:  st <= IDLE;
                default: st <= IDLE;
            endcase
            if (ctrl_clear) begin
                wr_ptr <= '0;
                count  <= '0;
                st     <= IDLE;
            end
            if (pass_done) done <= 1'b1;
        end
    end

    // Write and playback never overlap: writes are refused while the player is busy.
    assign sram_csb0  = ~(wr_en | pb_rd_en);
    assign sram_web0  = ~wr_en;
    assign sram_addr0 = wr_en ? wr_addr : pb_rd_addr;
    assign sram_din0  = wr_din;

    trace_player #(
        .ADDR_W (ADDR_W),
        .GAP    (GAP)
    ) u_player (
        .clk         (clk),
        .rst_n       (reset_n),
        .start       (pb_start),
        .abort       (ctrl_clear),
        .loop        (loop_en),
        .count       (count),
        .sram_dout   (sram_dout0),
        .rd_en       (pb_rd_en),
        .rd_addr     (pb_rd_addr),
        .trace_ready (trace_ready_o),
        .trace_addr  (trace_addr_o),
        .busy        (busy),
        .pass_done   (pass_done)
    );

endmodule

// File: tb/tb_trace_sram_loader.sv
// tb/tb_trace_sram_loader.sv - scoreboard bench for trace_sram_loader with a behavioural SRAM
module tb_trace_sram_loader;

    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_DATA   = BASE + 32'h8;
    localparam logic [31:0] A_COUNT  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        sram_csb0, sram_web0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0 = '0;
    logic        trace_ready_o;
    logic [31:0] trace_addr_o;
    logic        irq_o;

    typedef struct { logic [31:0] data; int lat; int issue; } bus_exp_t;
    typedef struct { logic [31:0] addr; int gap; } tr_exp_t;

    bus_exp_t bus_q[$];
    tr_exp_t  tr_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tr = 0;
    int sram_wr_cnt = 0;
    logic [31:0] mem [0:255];

    trace_sram_loader dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .sram_csb0     (sram_csb0),
        .sram_web0     (sram_web0),
        .sram_addr0    (sram_addr0),
        .sram_din0     (sram_din0),
        .sram_dout0    (sram_dout0),
        .trace_ready_o (trace_ready_o),
        .trace_addr_o  (trace_addr_o),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                mem[sram_addr0] <= sram_din0;
                sram_wr_cnt     <= sram_wr_cnt + 1;
            end else begin
                sram_dout0 <= mem[sram_addr0];
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        bus_exp_t be;
        tr_exp_t  te;
        forever begin
            @(negedge clk);
            if (wbs_ack_o) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_ack unexpected ack data=%h at cycle %0d", wbs_dat_o, cyc);
                end else begin
                    be = bus_q.pop_front();
                    if (wbs_dat_o !== be.data || (cyc - be.issue) != be.lat) begin
                        errors++;
                        $display("FAIL bus_ack got data=%h lat=%0d, expected data=%h lat=%0d",
                                 wbs_dat_o, cyc - be.issue, be.data, be.lat);
                    end
                end
            end
            if (trace_ready_o) begin
                checks++;
                if (tr_q.size() == 0) begin
                    errors++;
                    $display("FAIL trace unexpected strobe addr=%h at cycle %0d", trace_addr_o, cyc);
                end else begin
                    te = tr_q.pop_front();
                    if (trace_addr_o !== te.addr || (te.gap != 0 && (cyc - last_tr) != te.gap)) begin
                        errors++;
                        $display("FAIL trace got addr=%h spacing=%0d, expected addr=%h spacing=%0d",
                                 trace_addr_o, cyc - last_tr, te.addr, te.gap);
                    end
                end
                last_tr = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_d, input int exp_lat);
        bus_exp_t e;
        int n;
        @(negedge clk);
        e.data  = exp_d;
        e.lat   = exp_lat;
        e.issue = cyc;
        bus_q.push_back(e);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = w; wbs_adr_i = a; wbs_dat_i = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wbs_ack_o && n < 20);
        if (!wbs_ack_o) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout adr=%h no ack within %0d cycles", a, n);
            bus_q.delete(bus_q.size() - 1);
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; wbs_dat_i = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_d);
        wb(1'b0, a, 32'h0, exp_d, 1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wb(1'b1, a, d, 32'h0, 1);
    endtask

    task automatic expect_tr(input logic [31:0] a, input int gap);
        tr_exp_t t;
        t.addr = a;
        t.gap  = gap;
        tr_q.push_back(t);
    endtask

    task automatic wait_tr_empty(input string name, input int max);
        int n = 0;
        while (tr_q.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        chk(name, tr_q.size(), 0);
    endtask

    task automatic wait_irq(input string name, input int max);
        int n = 0;
        while (!irq_o && n < max) begin
            @(posedge clk);
            n++;
        end
        chk(name, irq_o, 1);
    endtask

    initial begin
        int save_wr;
        int n_ack;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", wbs_ack_o, 0);
        chk("rst_dat", wbs_dat_o, 0);
        chk("rst_csb_web", {sram_csb0, sram_web0}, 2'b11);
        chk("rst_addr_din", {sram_addr0, sram_din0}, 0);
        chk("rst_trace", {trace_ready_o, trace_addr_o, irq_o}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        rd(A_COUNT, 32'h0);
        rd(A_STATUS, 32'h0);

        // START with nothing loaded: done immediately, no strobes.
        wr(A_CTRL, 32'h1);
        chk("empty_start_irq", irq_o, 1);
        rd(A_STATUS, 32'h2);
        wr(A_STATUS, 32'h2);
        rd(A_STATUS, 32'h0);
        chk("done_clear_irq", irq_o, 0);

        // Load three words; each accepted DATA write acks after 2 cycles.
        wb(1'b1, A_DATA, 32'h1000, 32'h0, 2);
        wb(1'b1, A_DATA, 32'h2000, 32'h0, 2);
        wb(1'b1, A_DATA, 32'h3000, 32'h0, 2);
        chk("mem0", mem[0], 32'h1000);
        chk("mem1", mem[1], 32'h2000);
        chk("mem2", mem[2], 32'h3000);
        rd(A_COUNT, 32'd3);

        // Playback: three strobes 7 cycles apart.
        expect_tr(32'h1000, 0);
        expect_tr(32'h2000, 7);
        expect_tr(32'h3000, 7);
        wr(A_CTRL, 32'h1);
        wait_irq("pb1_irq", 100);
        wait_tr_empty("pb1_strobes", 10);
        rd(A_STATUS, 32'h2);
        wr(A_STATUS, 32'h2);

        // Second playback with a STATUS read and a refused DATA write while busy.
        expect_tr(32'h1000, 0);
        expect_tr(32'h2000, 7);
        expect_tr(32'h3000, 7);
        wr(A_CTRL, 32'h1);
        rd(A_STATUS, 32'h1);
        save_wr = sram_wr_cnt;
        wb(1'b1, A_DATA, 32'hDEAD_BEEF, 32'h0, 1);
        @(posedge clk);
        chk("busy_write_sram_untouched", sram_wr_cnt, save_wr);
        wait_irq("pb2_irq", 100);
        wait_tr_empty("pb2_strobes", 10);
        rd(A_STATUS, 32'hA);
        rd(A_COUNT, 32'd3);
        wr(A_STATUS, 32'hA);
        rd(A_STATUS, 32'h0);

        // CLEAR after the second strobe: third strobe must never appear.
        expect_tr(32'h1000, 0);
        expect_tr(32'h2000, 7);
        wr(A_CTRL, 32'h1);
        wait_tr_empty("clr_two_strobes", 40);
        wr(A_CTRL, 32'h2);
        repeat (30) @(posedge clk);
        chk("clr_queue", tr_q.size(), 0);
        rd(A_COUNT, 32'h0);
        rd(A_STATUS, 32'h0);
        chk("clr_irq", irq_o, 0);

        // Fill to 256 words, the 257th is refused.
        for (int i = 0; i < 257; i++) begin
            wb(1'b1, A_DATA, 32'h100 + i, 32'h0, (i < 256) ? 2 : 1);
        end
        rd(A_STATUS, 32'hC);
        rd(A_COUNT, 32'd256);
        chk("mem255", mem[255], 32'h1FF);
        wr(A_STATUS, 32'h8);
        rd(A_STATUS, 32'h4);

        // Access just past the register window is never acked.
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h10;
        n_ack = 0;
        repeat (6) begin
            @(negedge clk);
            if (wbs_ack_o) n_ack++;
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        chk("oow_no_ack", n_ack, 0);

        // Reset while the second word's SRAM read is in progress.
        expect_tr(32'h100, 0);
        wr(A_CTRL, 32'h1);
        wait_tr_empty("rst_first_strobe", 40);
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_read_active", {sram_csb0, sram_web0}, 2'b01);
        reset_n = 1'b0;
        #1;
        chk("async_rst_csb_web", {sram_csb0, sram_web0}, 2'b11);
        chk("async_rst_trace", {trace_ready_o, trace_addr_o}, 0);
        chk("async_rst_irq_ack", {irq_o, wbs_ack_o}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rd(A_COUNT, 32'h0);
        rd(A_STATUS, 32'h0);
        repeat (20) @(posedge clk);

        chk("bus_queue_drained", bus_q.size(), 0);
        chk("trace_queue_drained", tr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
